// File: rtl/mem_req_arbiter_if.sv
// ---------------------------------------------------------------------------
// Interfaces used by mem_req_arbiter.
//
// mem_req_port_if : one requester channel (CPU load/store unit or debug/IO
//                   loader).
//   req    requester -> arbiter  request, held with fields stable until done
//   rw     requester -> arbiter  1 = write, 0 = read
//   addr   requester -> arbiter  byte address
//   wdata  requester -> arbiter  write data
//   done   arbiter -> requester  one-cycle completion pulse
//   rdata  arbiter -> requester  read data, valid while done = 1
//   err    arbiter -> requester  timeout flag, valid with done
//   modport master = requester side, modport slave = arbiter side.
//
// mem_req_arbiter_if : single-port data memory request bus.
//   mem_req_valid   arbiter -> memory  request
//   mem_req_rw      arbiter -> memory  request direction
//   mem_req_addr    arbiter -> memory  request address
//   mem_data_write  arbiter -> memory  write data
//   mem_data_read   memory -> arbiter  read data
//   mem_ready       memory -> arbiter  ready, registered inside the memory
//   modport master = arbiter side, modport slave = memory side.
//
// Handshake: the memory performs an access on a rising edge where
// mem_req_valid=1 and mem_ready=0, then raises mem_ready. It drops mem_ready
// on the next edge where mem_req_valid=1 and mem_ready=1. The master must
// therefore hold mem_req_valid low in the cycle after an acknowledge, or the
// memory starts a duplicate access.
// ---------------------------------------------------------------------------
interface mem_req_port_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic          rw;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          done;
  logic [DW-1:0] rdata;
  logic          err;

  modport master (output req, rw, addr, wdata, input done, rdata, err);
  modport slave  (input req, rw, addr, wdata, output done, rdata, err);
endinterface

interface mem_req_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          mem_req_valid;
  logic          mem_req_rw;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_data_write;
  logic [DW-1:0] mem_data_read;
  logic          mem_ready;

  modport master (output mem_req_valid, mem_req_rw, mem_req_addr, mem_data_write,
                  input mem_data_read, mem_ready);
  modport slave  (input mem_req_valid, mem_req_rw, mem_req_addr, mem_data_write,
                  output mem_data_read, mem_ready);
endinterface

// File: rtl/mem_req_arbiter.sv
// ---------------------------------------------------------------------------
// mem_req_arbiter
//
// Shares the single-port data memory between two requesters: port 0 (CPU
// load/store unit) and port 1 (debug/IO loader). Sequences the memory's
// registered-ready protocol, arbitrates round-robin (or fixed priority) and
// returns a one-cycle done pulse with read data to the winning requester.
//
// Parameters:
//   AW             address width
//   DW             data width
//   FIXED_PRIO     1 = port 0 always wins, 0 = round-robin
//   TIMEOUT_CYCLES REQ cycles before an access is aborted (timeout build only)
//
// Optional feature macro: MEM_ARB_TIMEOUT_EN
//   defined   : a REQ-cycle counter aborts a stalled access with err=1 and
//               rdata=32'hDEADBEEF
//   undefined : REQ waits indefinitely, m0.err / m1.err are tied 0
//
// Ports:
//   CLK       rising-edge clock
//   RESET     asynchronous, active-high reset
//   m0, m1    requester channels (mem_req_port_if.slave)
//   mem       memory request bus (mem_req_arbiter_if.master)
//   busy      high in any state other than IDLE
//   grant_id  port currently or last served
//   dbg_state current FSM state (IDLE=0, REQ=1, DONE=2, FLUSH=3)
//
// FSM: IDLE -> REQ -> DONE -> IDLE for an access; IDLE -> FLUSH -> IDLE when
// a stale mem_ready is seen while idle. FLUSH drives valid=1, rw=0, addr=0 for
// one cycle so the memory drops ready without starting an access.
// ---------------------------------------------------------------------------
module mem_req_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int FIXED_PRIO     = 0,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                CLK,
  input  logic                RESET,
  mem_req_port_if.slave       m0,
  mem_req_port_if.slave       m1,
  mem_req_arbiter_if.master   mem,
  output logic                busy,
  output logic                grant_id,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DONE  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  // A zero timeout would abort every access before the memory could answer.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_cycles_invalid
  end

  state_t        state_q, state_d;
  logic          rr_ptr_q;
  logic          grant_q, grant_d;
  logic          rw_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata0_q, rdata1_q;

  // Arbitration and latch controls
  logic          pick1;
  logic          load;
  logic          capture;
  logic [DW-1:0] capture_data;
  logic          sel_rw;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int          TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            timeout_hit;
  logic            err_q;
`endif

  // -------------------------------------------------------------------------
  // Winner selection. A single requester always wins; with both requesting
  // the round-robin pointer decides unless fixed priority is configured.
  // -------------------------------------------------------------------------
  always_comb begin
    pick1 = 1'b0;
    if (FIXED_PRIO != 0) begin
      pick1 = !m0.req;
    end else if (m0.req && m1.req) begin
      pick1 = rr_ptr_q;
    end else begin
      pick1 = m1.req;
    end
  end

  assign sel_rw    = pick1 ? m1.rw    : m0.rw;
  assign sel_addr  = pick1 ? m1.addr  : m0.addr;
  assign sel_wdata = pick1 ? m1.wdata : m0.wdata;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    load         = 1'b0;
    capture      = 1'b0;
    // Writes return zero read data.
    capture_data = rw_q ? '0 : mem.mem_data_read;
`ifdef MEM_ARB_TIMEOUT_EN
    timeout_hit  = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        // A ready left over from an earlier access must be cleared before a
        // new request, otherwise it would be taken as this access's ack.
        if (mem.mem_ready) begin
          state_d = FLUSH;
        end else if (m0.req || m1.req) begin
          grant_d = pick1;
          load    = 1'b1;
          state_d = REQ;
        end
      end

      REQ: begin
        if (mem.mem_ready) begin
          capture = 1'b1;
          state_d = DONE;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          capture      = 1'b1;
          capture_data = DW'(32'hDEADBEEF);
          timeout_hit  = 1'b1;
          state_d      = DONE;
        end
`endif
      end

      DONE:  state_d = IDLE;
      FLUSH: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      rr_ptr_q <= 1'b0;
      grant_q  <= 1'b0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;

      if (load) begin
        rw_q    <= sel_rw;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
      end

      // Each port's rdata holds until that port's next completion.
      if (capture) begin
        if (grant_q) begin
          rdata1_q <= capture_data;
        end else begin
          rdata0_q <= capture_data;
        end
      end

      // The port just served moves to the back of the queue.
      if (state_q == DONE) begin
        rr_ptr_q <= ~grant_q;
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  // Counts completed REQ cycles; restarts on every REQ entry.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_q == REQ && state_d == REQ) begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end else begin
        to_cnt_q <= '0;
      end
      if (capture) begin
        err_q <= timeout_hit;
      end
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // Valid is high in REQ and FLUSH only, so it is always low in the cycle
  // after an ack (DONE or IDLE) and the memory never sees a duplicate access.
  assign mem.mem_req_valid  = (state_q == REQ) || (state_q == FLUSH);
  assign mem.mem_req_rw     = (state_q == REQ) && rw_q;
  assign mem.mem_req_addr   = (state_q == REQ) ? addr_q  : '0;
  assign mem.mem_data_write = (state_q == REQ) ? wdata_q : '0;

  assign m0.done  = (state_q == DONE) && !grant_q;
  assign m1.done  = (state_q == DONE) &&  grant_q;
  assign m0.rdata = rdata0_q;
  assign m1.rdata = rdata1_q;

`ifdef MEM_ARB_TIMEOUT_EN
  assign m0.err = m0.done && err_q;
  assign m1.err = m1.done && err_q;
`else
  assign m0.err = 1'b0;
  assign m1.err = 1'b0;
`endif

  assign busy      = (state_q != IDLE);
  assign grant_id  = grant_q;
  assign dbg_state = state_q;

endmodule
